// File: rtl/ifetch_if.sv
// ifetch_if: fetch-control bundle covering redirect, memory request/response and instruction-buffer push
// Ports (master = ifetch_ctrl side):
//   redirect_valid/redirect_pc            new fetch target
//   req_valid_o/req_addr_o/req_ready_i    memory request channel
//   rsp_valid_i/rsp_data_i/rsp_err_i      in-order memory response channel
//   flush_o/data_o/valid_o/ready_i        instruction buffer push channel {fault, pc, instr}
interface ifetch_if #(
  parameter int XLEN = 32
);
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              req_valid_o;
  logic [XLEN-1:0]   req_addr_o;
  logic              req_ready_i;
  logic              rsp_valid_i;
  logic [XLEN-1:0]   rsp_data_i;
  logic              rsp_err_i;
  logic              flush_o;
  logic [2*XLEN:0]   data_o;
  logic              valid_o;
  logic              ready_i;
  modport master (
    input  redirect_valid, redirect_pc, req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, ready_i,
    output req_valid_o, req_addr_o, flush_o, data_o, valid_o
  );
  modport slave (
    output redirect_valid, redirect_pc, req_ready_i, rsp_valid_i, rsp_data_i, rsp_err_i, ready_i,
    input  req_valid_o, req_addr_o, flush_o, data_o, valid_o
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: sequential instruction fetch with bounded outstanding requests feeding the instruction buffer
// Ports: clk, rst (sync, active-high); bus (ifetch_if.master) carries redirect, memory request/response
// and the {fault, pc, instr} push channel with its flush pulse.
module ifetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              OUTST    = 2
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);
  localparam int CW = $clog2(OUTST + 1);
  localparam int PW = $clog2(OUTST);
  localparam int EW = 2 * XLEN + 1;
  typedef enum logic {RUN, HALT} state_t;
  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, drop_q, drop_d, qcount_q, qcount_d;
  logic [PW-1:0]   qhead_q, qhead_d, qtail_q, qtail_d, phead_q, phead_d, ptail_q, ptail_d;
  logic [EW-1:0]   q_q [OUTST];
  logic [EW-1:0]   q_d [OUTST];
  logic [XLEN-1:0] pcq_q [OUTST];
  logic [XLEN-1:0] pcq_d [OUTST];
  logic            req_valid, q_valid, issue, rsp, keep, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(OUTST - 1)) ? '0 : p + PW'(1);
  endfunction
  assign bus.req_valid_o = req_valid;
  assign bus.req_addr_o  = pc_q;
  assign bus.flush_o     = bus.redirect_valid;
  assign bus.valid_o     = q_valid;
  assign bus.data_o      = q_q[qhead_q];
  always_comb begin
    req_valid = (state_q == RUN) && !bus.redirect_valid &&
                (({1'b0, inflight_q} + {1'b0, qcount_q}) < (CW + 1)'(OUTST));
    q_valid   = qcount_q != '0;
    issue     = req_valid && bus.req_ready_i;
    rsp       = bus.rsp_valid_i;
    keep      = rsp && drop_q == '0 && !bus.redirect_valid;
    pop       = q_valid && bus.ready_i && !bus.redirect_valid;
    inflight_d = inflight_q + CW'(issue) - CW'(rsp);
    // the pc queue tracks every request, so it keeps popping on dropped responses and survives redirects
    pcq_d   = pcq_q;
    q_d     = q_q;
    ptail_d = issue ? inc(ptail_q) : ptail_q;
    phead_d = rsp ? inc(phead_q) : phead_q;
    if (issue) pcq_d[ptail_q] = pc_q;
    if (keep) q_d[qtail_q] = {bus.rsp_err_i, pcq_q[phead_q], bus.rsp_data_i};
    pc_d     = issue ? pc_q + XLEN'(4) : pc_q;
    state_d  = (keep && bus.rsp_err_i) ? HALT : state_q;
    // a fault drops everything younger, including a request issued on the same edge
    drop_d   = (keep && bus.rsp_err_i) ? inflight_d :
               (rsp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    qcount_d = qcount_q + CW'(keep) - CW'(pop);
    qhead_d  = pop ? inc(qhead_q) : qhead_q;
    qtail_d  = keep ? inc(qtail_q) : qtail_q;
    if (bus.redirect_valid) begin
      pc_d     = {bus.redirect_pc[XLEN-1:2], 2'b00};
      state_d  = RUN;
      drop_d   = inflight_d;
      qcount_d = '0;
      qhead_d  = '0;
      qtail_d  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      state_q    <= RUN;
      inflight_q <= '0;
      drop_q     <= '0;
      qcount_q   <= '0;
      qhead_q    <= '0;
      qtail_q    <= '0;
      phead_q    <= '0;
      ptail_q    <= '0;
      q_q        <= '{default: '0};
      pcq_q      <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      qcount_q   <= qcount_d;
      qhead_q    <= qhead_d;
      qtail_q    <= qtail_d;
      phead_q    <= phead_d;
      ptail_q    <= ptail_d;
      q_q        <= q_d;
      pcq_q      <= pcq_d;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, inflight_q} + {1'b0, qcount_q}) <= (CW + 1)'(OUTST));
  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
    bus.rsp_valid_i |-> inflight_q != '0);
endmodule
